// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer for the EX stage.
// Owns HI/LO and a single shared datapath. MULT/MULTU use shift-add and DIV/DIVU use
// restoring division, each producing one bit per cycle. The pipeline is held through
// stallreq until the result is ready, and the result is then committed to HI/LO.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; accepts start, services MTHI/MTLO
// MUL    | shift-add iterations, cnt = 0 .. WIDTH-1
// DIV    | restoring-divide iterations, cnt = 0 .. WIDTH-1
// DONE   | sign fix-up, done pulse, HI/LO committed at end of cycle
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stallreq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 neg_q;
    logic                 neg_r;
    logic                 is_div;
    logic                 div0;

    logic                 accept;
    logic                 is_signed;
    logic                 last_iter;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    // op[0] clear selects the signed variants (MULT, DIV)
    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_abs     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and control outputs
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stallreq  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        res_hi    = '0;
        res_lo    = '0;
        hi_o      = hi_r;
        lo_o      = lo_r;
        case (state)
            S_IDLE: begin
                if (start && !cancel) begin
                    accept    = 1'b1;
                    stallreq  = 1'b1;
                    state_nxt = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                stallreq = 1'b1;
                busy     = 1'b1;
                if (cancel) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately ignored here so the held instruction is not re-issued
                done      = 1'b1;
                res_hi    = fix_hi;
                res_lo    = fix_lo;
                hi_o      = fix_hi;
                lo_o      = fix_lo;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One iteration step of either algorithm, plus the final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_trial = div_shift - {1'b0, opnd};
        prod_fix  = neg_q ? -acc : acc;
        // divide by zero: all-ones quotient; remainder ends up as |a| and the sign fix restores a
        quo_fix   = div0 ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi    = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = is_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Operand latch on accept, then one bit per cycle in MUL/DIV
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r  <= is_signed & src_a[WIDTH-1];
                        div0   <= op[1] & (src_b == '0);
                        if (op[1]) begin
                            opnd <= b_abs;
                            acc  <= {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            opnd <= a_abs;
                            acc  <= {{WIDTH{1'b0}}, b_abs};
                        end
                    end
                end
                S_MUL: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                S_DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                            acc[WIDTH-2:0], div_ge};
                end
                default: ;
            endcase
        end
    end

    // HI/LO: MTHI/MTLO only while idle; the result commit in DONE is the only other writer.
    // A flush arriving in DONE kills the instruction, so the commit is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state == S_DONE) begin
            if (!cancel) begin
                hi_r <= fix_hi;
                lo_r <= fix_lo;
            end
        end else if (state == S_IDLE) begin
            if (hi_we) begin
                hi_r <= wdata;
            end
            if (lo_we) begin
                lo_r <= wdata;
            end
        end
    end

endmodule
